// File: rtl/riscv_pkg.sv
// Shared types, opcode/funct3 constants and access helpers for the memory access unit.
package riscv_pkg;

    localparam int unsigned N    = 32;
    localparam int unsigned BE_W = N / 8;

    typedef logic [6:0] opcode_t;
    typedef logic [2:0] funct3_t;

    localparam opcode_t OPCODE_LOAD    = 7'b0000011;
    localparam opcode_t OPCODE_STORE   = 7'b0100011;
    localparam opcode_t OPCODE_REG_IMM = 7'b0010011;
    localparam opcode_t OPCODE_REG_REG = 7'b0110011;

    localparam funct3_t F3_LB  = 3'b000;
    localparam funct3_t F3_LH  = 3'b001;
    localparam funct3_t F3_LW  = 3'b010;
    localparam funct3_t F3_LBU = 3'b100;
    localparam funct3_t F3_LHU = 3'b101;
    localparam funct3_t F3_SB  = 3'b000;
    localparam funct3_t F3_SH  = 3'b001;
    localparam funct3_t F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_RESP = 2'd2
    } mem_state_t;

    // Context of the in-flight memory access, held from accept to retire.
    typedef struct packed {
        logic       is_store;
        funct3_t    f3;
        logic [1:0] lane;
        logic [4:0] rd;
    } mem_op_t;

    function automatic logic load_f3_ok(funct3_t f3);
        logic ok;
        ok = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
             (f3 == F3_LBU) || (f3 == F3_LHU);
        return ok;
    endfunction

    function automatic logic store_f3_ok(funct3_t f3);
        logic ok;
        ok = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        return ok;
    endfunction

    // funct3[1:0] encodes the access size for both loads and stores.
    function automatic logic misaligned(funct3_t f3, logic [1:0] lo);
        logic m;
        case (f3[1:0])
            2'b01:   m = lo[0];
            2'b10:   m = (lo != 2'b00);
            default: m = 1'b0;
        endcase
        return m;
    endfunction

    function automatic logic [1:0] force_align(funct3_t f3, logic [1:0] lo);
        logic [1:0] a;
        case (f3[1:0])
            2'b01:   a = {lo[1], 1'b0};
            2'b10:   a = 2'b00;
            default: a = lo;
        endcase
        return a;
    endfunction

    function automatic logic [BE_W-1:0] store_be(funct3_t f3, logic [1:0] lo);
        logic [BE_W-1:0] be;
        case (f3)
            F3_SB:   be = BE_W'(4'b0001) << lo;
            F3_SH:   be = BE_W'(4'b0011) << lo;
            default: be = '1;
        endcase
        return be;
    endfunction

    function automatic logic [N-1:0] store_lanes(funct3_t f3, logic [N-1:0] d);
        logic [N-1:0] w;
        case (f3)
            F3_SB:   w = {4{d[7:0]}};
            F3_SH:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half lane of a returned word and sign/zero extends it.
module load_extend
    import riscv_pkg::*;
(
    input  logic [N-1:0] rdata,
    input  logic [1:0]   lane,
    input  funct3_t      funct3,
    output logic [N-1:0] result_c
);

    logic [7:0]  byte_c;
    logic [15:0] half_c;

    // Lane multiplexers
    always_comb begin
        byte_c = rdata[7:0];
        case (lane)
            2'd1:    byte_c = rdata[15:8];
            2'd2:    byte_c = rdata[23:16];
            2'd3:    byte_c = rdata[31:24];
            default: byte_c = rdata[7:0];
        endcase
        half_c = lane[1] ? rdata[31:16] : rdata[15:0];
    end

    // Extension by access type
    always_comb begin
        result_c = rdata;
        case (funct3)
            F3_LB:   result_c = {{24{byte_c[7]}}, byte_c};
            F3_LH:   result_c = {{16{half_c[15]}}, half_c};
            F3_LBU:  result_c = {24'd0, byte_c};
            F3_LHU:  result_c = {16'd0, half_c};
            default: result_c = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between execute and writeback: issues data-memory requests,
// aligns store data, extends load data and retires every accepted instruction.
// Build option: MEM_MISALIGN_TRAP_EN traps misaligned accesses instead of
// silently forcing alignment.
module mem_access_unit
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  opcode_t         opcode,
    input  funct3_t         funct3,
    input  logic [N-1:0]    alu_result,
    input  logic [N-1:0]    store_data,
    input  logic [4:0]      rd_addr,
    input  logic            flush,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [N-1:0]    dmem_addr,
    output logic [N-1:0]    dmem_wdata,
    output logic [BE_W-1:0] dmem_be,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [N-1:0]    dmem_rdata,
    output logic            wb_valid,
    output logic            wb_we,
    output logic [4:0]      wb_rd,
    output logic [N-1:0]    wb_data,
    output logic            misalign_exc
);

    mem_state_t      state, state_d;
    mem_op_t         op_q, op_d;
    logic            kill_q, kill_d;

    logic            dmem_req_d, dmem_we_d;
    logic [N-1:0]    dmem_addr_d, dmem_wdata_d;
    logic [BE_W-1:0] dmem_be_d;
    logic            wb_valid_d, wb_we_d;
    logic [4:0]      wb_rd_d;
    logic [N-1:0]    wb_data_d;

    logic            accept, is_load, is_store, is_mem, f3_ok, trap;
    logic [1:0]      lane;
    logic [N-1:0]    load_data_c;

    assign ex_ready = (state == IDLE);
    assign accept   = ex_valid & ex_ready & ~flush;
    assign is_load  = (opcode == OPCODE_LOAD);
    assign is_store = (opcode == OPCODE_STORE);
    assign is_mem   = is_load | is_store;
    assign f3_ok    = is_store ? store_f3_ok(funct3) : load_f3_ok(funct3);

`ifdef MEM_MISALIGN_TRAP_EN
    assign lane = alu_result[1:0];
    assign trap = is_mem & f3_ok & misaligned(funct3, alu_result[1:0]);

    // Exception pulse the cycle after a trapped access is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) misalign_exc <= 1'b0;
        else        misalign_exc <= accept & trap;
    end
`else
    assign lane = force_align(funct3, alu_result[1:0]);
    assign trap = 1'b0;
    assign misalign_exc = 1'b0;
`endif

    load_extend u_load_extend (
        .rdata    (dmem_rdata),
        .lane     (op_q.lane),
        .funct3   (op_q.f3),
        .result_c (load_data_c)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        case (state)
            IDLE:      if (accept & is_mem & f3_ok & ~trap) state_d = REQ;
            REQ: begin
                if (dmem_gnt)   state_d = op_q.is_store ? IDLE : WAIT_RESP;
                else if (flush) state_d = IDLE;
            end
            WAIT_RESP: if (dmem_rvalid) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and access context
    always_comb begin
        dmem_req_d   = dmem_req;
        dmem_we_d    = dmem_we;
        dmem_addr_d  = dmem_addr;
        dmem_wdata_d = dmem_wdata;
        dmem_be_d    = dmem_be;
        wb_valid_d   = 1'b0;
        wb_we_d      = 1'b0;
        wb_rd_d      = wb_rd;
        wb_data_d    = wb_data;
        op_d         = op_q;
        kill_d       = kill_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!is_mem) begin
                        wb_valid_d = 1'b1;
                        wb_we_d    = (rd_addr != 5'd0);
                        wb_rd_d    = rd_addr;
                        wb_data_d  = alu_result;
                    end else if (!f3_ok) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd_addr;
                    end else if (!trap) begin
                        dmem_req_d   = 1'b1;
                        dmem_we_d    = is_store;
                        dmem_addr_d  = {alu_result[N-1:2], 2'b00};
                        dmem_be_d    = is_store ? store_be(funct3, lane) : '1;
                        dmem_wdata_d = is_store ? store_lanes(funct3, store_data) : '0;
                        op_d.is_store = is_store;
                        op_d.f3       = funct3;
                        op_d.lane     = lane;
                        op_d.rd       = rd_addr;
                        kill_d        = 1'b0;
                    end
                end
            end
            REQ: begin
                if (dmem_gnt || flush) begin
                    dmem_req_d = 1'b0;
                    dmem_we_d  = 1'b0;
                    dmem_be_d  = '0;
                end
                if (dmem_gnt) begin
                    if (op_q.is_store) begin
                        wb_valid_d = ~flush;
                        wb_rd_d    = op_q.rd;
                    end else begin
                        kill_d = flush;
                    end
                end
            end
            WAIT_RESP: begin
                if (dmem_rvalid) begin
                    wb_valid_d = ~(kill_q | flush);
                    if (!(kill_q | flush)) begin
                        wb_we_d   = (op_q.rd != 5'd0);
                        wb_rd_d   = op_q.rd;
                        wb_data_d = load_data_c;
                    end
                end else if (flush) begin
                    kill_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Output and context registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_be    <= '0;
            wb_valid   <= 1'b0;
            wb_we      <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            op_q       <= '0;
            kill_q     <= 1'b0;
        end else begin
            dmem_req   <= dmem_req_d;
            dmem_we    <= dmem_we_d;
            dmem_addr  <= dmem_addr_d;
            dmem_wdata <= dmem_wdata_d;
            dmem_be    <= dmem_be_d;
            wb_valid   <= wb_valid_d;
            wb_we      <= wb_we_d;
            wb_rd      <= wb_rd_d;
            wb_data    <= wb_data_d;
            op_q       <= op_d;
            kill_q     <= kill_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: writeback scoreboard plus per-scenario checks.
module tb_mem_access_unit;
    import riscv_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ex_valid;
    logic         ex_ready;
    opcode_t      opcode;
    funct3_t      funct3;
    logic [31:0]  alu_result;
    logic [31:0]  store_data;
    logic [4:0]   rd_addr;
    logic         flush;
    logic         dmem_req, dmem_we;
    logic [31:0]  dmem_addr, dmem_wdata;
    logic [3:0]   dmem_be;
    logic         dmem_gnt, dmem_rvalid;
    logic [31:0]  dmem_rdata;
    logic         wb_valid, wb_we;
    logic [4:0]   wb_rd;
    logic [31:0]  wb_data;
    logic         misalign_exc;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        chk_data;
    } wb_exp_t;

    wb_exp_t exp_q[$];
    wb_exp_t mon_e;

    mem_access_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .opcode       (opcode),
        .funct3       (funct3),
        .alu_result   (alu_result),
        .store_data   (store_data),
        .rd_addr      (rd_addr),
        .flush        (flush),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_be      (dmem_be),
        .dmem_gnt     (dmem_gnt),
        .dmem_rvalid  (dmem_rvalid),
        .dmem_rdata   (dmem_rdata),
        .wb_valid     (wb_valid),
        .wb_we        (wb_we),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .misalign_exc (misalign_exc)
    );

    always #5 clk = ~clk;

    // Scoreboard: every writeback pulse must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n === 1'b1 && wb_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL wb_unexpected: got wb_valid=1 rd=%0d data=%h, required no writeback", wb_rd, wb_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (wb_we !== mon_e.we || wb_rd !== mon_e.rd ||
                    (mon_e.chk_data && wb_data !== mon_e.data)) begin
                    failures++;
                    $display("FAIL wb_scoreboard: got we=%b rd=%0d data=%h, required we=%b rd=%0d data=%h",
                             wb_we, wb_rd, wb_data, mon_e.we, mon_e.rd, mon_e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(opcode_t op, funct3_t f3, logic [31:0] a, logic [31:0] sd, logic [4:0] rd);
        ex_valid   = 1'b1;
        opcode     = op;
        funct3     = f3;
        alu_result = a;
        store_data = sd;
        rd_addr    = rd;
        tick();
        ex_valid   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ex_valid = 1'b0; opcode = OPCODE_REG_REG; funct3 = 3'd0;
        alu_result = '0; store_data = '0; rd_addr = '0; flush = 1'b0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        #3;
        checks++; if (ex_ready !== 1'b1) begin failures++; $display("FAIL reset_ex_ready: got %b required 1", ex_ready); end
        checks++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || dmem_be !== 4'h0) begin failures++; $display("FAIL reset_dmem: got req=%b we=%b be=%b required 0", dmem_req, dmem_we, dmem_be); end
        checks++; if (wb_valid !== 1'b0 || wb_we !== 1'b0) begin failures++; $display("FAIL reset_wb: got valid=%b we=%b required 0", wb_valid, wb_we); end
        checks++; if (misalign_exc !== 1'b0) begin failures++; $display("FAIL reset_exc: got %b required 0", misalign_exc); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_alu();
        exp_q.push_back('{we: 1'b1, rd: 5'd5, data: 32'h0000_1234, chk_data: 1'b1});
        drive_op(OPCODE_REG_REG, 3'd0, 32'h0000_1234, 32'd0, 5'd5);
        checks++; if (wb_valid !== 1'b1 || ex_ready !== 1'b1) begin failures++; $display("FAIL alu_rd5: got wb_valid=%b ex_ready=%b required 1 1", wb_valid, ex_ready); end
        exp_q.push_back('{we: 1'b0, rd: 5'd0, data: 32'h0000_1234, chk_data: 1'b1});
        drive_op(OPCODE_REG_REG, 3'd0, 32'h0000_1234, 32'd0, 5'd0);
        exp_q.push_back('{we: 1'b1, rd: 5'd31, data: 32'hCAFE_F00D, chk_data: 1'b1});
        drive_op(OPCODE_REG_IMM, 3'd0, 32'hCAFE_F00D, 32'd0, 5'd31);
        tick();
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL alu_pulse: got wb_valid=%b required 0", wb_valid); end
    endtask

    task automatic test_store(funct3_t f3, logic [31:0] a, logic [31:0] sd, logic [4:0] rd,
                              logic [31:0] exp_addr, logic [3:0] exp_be, logic [31:0] exp_wdata, int gnt_delay);
        drive_op(OPCODE_STORE, f3, a, sd, rd);
        for (int i = 0; i <= gnt_delay; i++) begin
            checks++;
            if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== exp_addr ||
                dmem_be !== exp_be || dmem_wdata !== exp_wdata) begin
                failures++;
                $display("FAIL store_req cyc%0d: got req=%b we=%b addr=%h be=%b wdata=%h, required 1 1 %h %b %h",
                         i, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, exp_addr, exp_be, exp_wdata);
            end
            if (i == gnt_delay) begin
                exp_q.push_back('{we: 1'b0, rd: rd, data: 32'd0, chk_data: 1'b0});
                dmem_gnt = 1'b1;
            end
            tick();
        end
        dmem_gnt = 1'b0;
        checks++; if (dmem_req !== 1'b0 || wb_valid !== 1'b1 || wb_we !== 1'b0) begin failures++; $display("FAIL store_retire: got req=%b wb_valid=%b wb_we=%b required 0 1 0", dmem_req, wb_valid, wb_we); end
    endtask

    task automatic test_load(funct3_t f3, logic [31:0] a, logic [31:0] rdata, logic [4:0] rd,
                             logic [31:0] exp_addr, logic [31:0] exp_data, int rvalid_delay);
        drive_op(OPCODE_LOAD, f3, a, 32'd0, rd);
        checks++;
        if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_be !== 4'hF || dmem_addr !== exp_addr) begin
            failures++;
            $display("FAIL load_req: got req=%b we=%b be=%b addr=%h, required 1 0 1111 %h", dmem_req, dmem_we, dmem_be, dmem_addr, exp_addr);
        end
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        for (int i = 0; i < rvalid_delay; i++) begin
            checks++; if (ex_ready !== 1'b0 || dmem_req !== 1'b0) begin failures++; $display("FAIL load_wait cyc%0d: got ex_ready=%b req=%b required 0 0", i, ex_ready, dmem_req); end
            tick();
        end
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdata;
        exp_q.push_back('{we: (rd != 5'd0), rd: rd, data: exp_data, chk_data: 1'b1});
        tick();
        dmem_rvalid = 1'b0;
        dmem_rdata  = $urandom;
        checks++; if (wb_valid !== 1'b1 || ex_ready !== 1'b1) begin failures++; $display("FAIL load_retire: got wb_valid=%b ex_ready=%b required 1 1", wb_valid, ex_ready); end
    endtask

    task automatic test_flush_wait();
        drive_op(OPCODE_LOAD, F3_LW, 32'h0000_0300, 32'd0, 5'd9);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        flush = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (ex_ready !== 1'b0) begin failures++; $display("FAIL flush_wait_ready cyc%0d: got %b required 0", i, ex_ready); end
            tick();
            flush = 1'b0;
        end
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h1111_2222;
        tick();
        dmem_rvalid = 1'b0;
        checks++; if (wb_valid !== 1'b0 || ex_ready !== 1'b1) begin failures++; $display("FAIL flush_wait_retire: got wb_valid=%b ex_ready=%b required 0 1", wb_valid, ex_ready); end
    endtask

    task automatic test_flush_req();
        drive_op(OPCODE_STORE, F3_SW, 32'h0000_0400, 32'h5555_AAAA, 5'd1);
        checks++; if (dmem_req !== 1'b1) begin failures++; $display("FAIL flush_req_pre: got req=%b required 1", dmem_req); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (dmem_req !== 1'b0 || ex_ready !== 1'b1 || wb_valid !== 1'b0) begin failures++; $display("FAIL flush_req_withdraw: got req=%b ex_ready=%b wb_valid=%b required 0 1 0", dmem_req, ex_ready, wb_valid); end
        tick();
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL flush_req_nowb: got wb_valid=%b required 0", wb_valid); end
        ex_valid = 1'b1; flush = 1'b1; opcode = OPCODE_REG_REG; alu_result = 32'h77; rd_addr = 5'd3;
        tick();
        ex_valid = 1'b0; flush = 1'b0;
        checks++; if (wb_valid !== 1'b0 || dmem_req !== 1'b0 || ex_ready !== 1'b1) begin failures++; $display("FAIL flush_idle: got wb_valid=%b req=%b ex_ready=%b required 0 0 1", wb_valid, dmem_req, ex_ready); end
    endtask

    task automatic test_bad_f3();
        exp_q.push_back('{we: 1'b0, rd: 5'd12, data: 32'd0, chk_data: 1'b0});
        drive_op(OPCODE_LOAD, 3'b011, 32'h0000_0500, 32'd0, 5'd12);
        checks++; if (wb_valid !== 1'b1 || wb_we !== 1'b0 || dmem_req !== 1'b0) begin failures++; $display("FAIL bad_f3_load: got wb_valid=%b wb_we=%b req=%b required 1 0 0", wb_valid, wb_we, dmem_req); end
        exp_q.push_back('{we: 1'b0, rd: 5'd13, data: 32'd0, chk_data: 1'b0});
        drive_op(OPCODE_STORE, 3'b100, 32'h0000_0504, 32'h1, 5'd13);
        checks++; if (wb_valid !== 1'b1 || wb_we !== 1'b0 || dmem_req !== 1'b0) begin failures++; $display("FAIL bad_f3_store: got wb_valid=%b wb_we=%b req=%b required 1 0 0", wb_valid, wb_we, dmem_req); end
    endtask

    task automatic test_misalign();
`ifdef MEM_MISALIGN_TRAP_EN
        drive_op(OPCODE_LOAD, F3_LW, 32'h0000_0102, 32'd0, 5'd4);
        checks++; if (dmem_req !== 1'b0 || misalign_exc !== 1'b1 || wb_valid !== 1'b0) begin failures++; $display("FAIL trap_lw: got req=%b exc=%b wb_valid=%b required 0 1 0", dmem_req, misalign_exc, wb_valid); end
        tick();
        checks++; if (misalign_exc !== 1'b0 || ex_ready !== 1'b1) begin failures++; $display("FAIL trap_pulse: got exc=%b ex_ready=%b required 0 1", misalign_exc, ex_ready); end
`else
        test_load(F3_LW, 32'h0000_0102, 32'h89AB_CDEF, 5'd4, 32'h0000_0100, 32'h89AB_CDEF, 1);
        checks++; if (misalign_exc !== 1'b0) begin failures++; $display("FAIL align_exc: got %b required 0", misalign_exc); end
        test_store(F3_SH, 32'h0000_0103, 32'h0000_5678, 5'd6, 32'h0000_0100, 4'b1100, 32'h5678_5678, 0);
`endif
    endtask

    task automatic test_reset_mid();
        drive_op(OPCODE_STORE, F3_SW, 32'h0000_0600, 32'hDEAD_0001, 5'd2);
        checks++; if (dmem_req !== 1'b1) begin failures++; $display("FAIL rst_mid_pre: got req=%b required 1", dmem_req); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (dmem_req !== 1'b0 || ex_ready !== 1'b1 || wb_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_async: got req=%b ex_ready=%b wb_valid=%b required 0 1 0", dmem_req, ex_ready, wb_valid); end
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (wb_valid !== 1'b0 || dmem_req !== 1'b0) begin failures++; $display("FAIL rst_mid_after cyc%0d: got wb_valid=%b req=%b required 0 0", i, wb_valid, dmem_req); end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_store(F3_SB, 32'h0000_0103, 32'h0000_00AB, 5'd7, 32'h0000_0100, 4'b1000, 32'hABAB_ABAB, 2);
        test_store(F3_SH, 32'h0000_0102, 32'h1234_ABCD, 5'd8, 32'h0000_0100, 4'b1100, 32'hABCD_ABCD, 1);
        test_store(F3_SW, 32'h0000_0100, 32'h0102_0304, 5'd9, 32'h0000_0100, 4'b1111, 32'h0102_0304, 0);
        test_load(F3_LB,  32'h0000_0202, 32'h0080_0000, 5'd10, 32'h0000_0200, 32'hFFFF_FF80, 1);
        test_load(F3_LBU, 32'h0000_0202, 32'h0080_0000, 5'd11, 32'h0000_0200, 32'h0000_0080, 2);
        test_load(F3_LH,  32'h0000_0202, 32'h8001_0000, 5'd14, 32'h0000_0200, 32'hFFFF_8001, 1);
        test_load(F3_LHU, 32'h0000_0200, 32'h1234_8001, 5'd15, 32'h0000_0200, 32'h0000_8001, 1);
        test_load(F3_LW,  32'h0000_0204, 32'hDEAD_BEEF, 5'd0,  32'h0000_0204, 32'hDEAD_BEEF, 3);
        test_flush_wait();
        test_flush_req();
        test_bad_f3();
        test_misalign();
        test_reset_mid();
        repeat (2) tick();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL sb_drain: got %0d pending writebacks required 0", exp_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
